// File: rtl/wb_mux_ctrl.sv
// Write-back sequencer: owns the register-write-data mux select and the register-file
// write enable, holding each request until its source data is valid, then writing once.
module wb_mux_ctrl #(
  parameter int MD_TIMEOUT = 34
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_req,
  input  logic [2:0] wb_src,
  input  logic       mem_wait,
  input  logic       md_busy,
  input  logic       flush,
  output logic [2:0] mux_sel,
  output logic       reg_write,
  output logic       wb_ack,
  output logic       wb_err,
  output logic       busy,
  output logic [1:0] dbgState
);

  // Handshake: wb_req/wb_src are taken only on an edge where busy=0; the requester must
  // not present a new request until busy returns to 0. wb_ack marks the single write cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    WRITE = 2'b10
  } state_t;

  localparam logic [2:0] SRC_MDR     = 3'd1;
  localparam logic [2:0] SRC_HI      = 3'd2;
  localparam logic [2:0] SRC_LO      = 3'd3;
  localparam logic [2:0] SRC_ILLEGAL = 3'd7;
  localparam logic [7:0] CNT_LAST    = 8'(MD_TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       reqBlocked;
  logic       heldBlocked;

  function automatic logic srcBlocked(input logic [2:0] src, input logic memWait,
                                      input logic mdBusy);
    return ((src == SRC_MDR) && memWait) ||
           (((src == SRC_HI) || (src == SRC_LO)) && mdBusy);
  endfunction

  // In IDLE the incoming code decides; in WAIT the latched select is the source.
  assign reqBlocked  = srcBlocked(wb_src, mem_wait, md_busy);
  assign heldBlocked = srcBlocked(mux_sel, mem_wait, md_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      mux_sel <= 3'b000;
      wb_err  <= 1'b0;
    end else begin
      wb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_req && !flush) begin
            if (wb_src == SRC_ILLEGAL) begin
              wb_err <= 1'b1;
            end else begin
              mux_sel <= wb_src;
              cnt     <= 8'd0;
              state   <= reqBlocked ? WAIT : WRITE;
            end
          end
        end
        WAIT: begin
          // A clearing block beats a timeout landing on the same edge.
          if (flush) begin
            state <= IDLE;
          end else if (!heldBlocked) begin
            state <= WRITE;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE;
            wb_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WRITE: begin
          // Enable is already on the wire, so a flush here cannot stop the write.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign reg_write = (state == WRITE);
  assign wb_ack    = (state == WRITE);
  assign busy      = (state != IDLE);
  assign dbgState  = state;

  writeNotErr: assert property (@(posedge clk) disable iff (!rst_n) !(reg_write && wb_err));
  selStableBusy: assert property (@(posedge clk) disable iff (!rst_n)
    (busy && $past(busy)) |-> $stable(mux_sel));

endmodule

// File: tb/tb_wb_mux_ctrl.sv
// Bench for wb_mux_ctrl: two instances (short and default timeout) driven in lockstep
// from a directed table plus random transactions, checked cycle by cycle against a model.
module tb_wb_mux_ctrl;

  localparam int TM = 4;
  localparam int TL = 34;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_req;
  logic [2:0] wb_src;
  logic       mem_wait;
  logic       md_busy;
  logic       flush;

  logic [2:0] muxSelM, muxSelL;
  logic       regWriteM, regWriteL;
  logic       wbAckM, wbAckL;
  logic       wbErrM, wbErrL;
  logic       busyM, busyL;
  logic [1:0] dbgM, dbgL;

  wb_mux_ctrl #(.MD_TIMEOUT(TM)) uDutM (
    .clk(clk), .rst_n(rst_n), .wb_req(wb_req), .wb_src(wb_src), .mem_wait(mem_wait),
    .md_busy(md_busy), .flush(flush), .mux_sel(muxSelM), .reg_write(regWriteM),
    .wb_ack(wbAckM), .wb_err(wbErrM), .busy(busyM), .dbgState(dbgM)
  );

  wb_mux_ctrl #(.MD_TIMEOUT(TL)) uDutL (
    .clk(clk), .rst_n(rst_n), .wb_req(wb_req), .wb_src(wb_src), .mem_wait(mem_wait),
    .md_busy(md_busy), .flush(flush), .mux_sel(muxSelL), .reg_write(regWriteL),
    .wb_ack(wbAckL), .wb_err(wbErrL), .busy(busyL), .dbgState(dbgL)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int nCompared = 0;
  int nMismatched = 0;
  logic [6:0] expM_q[$];
  logic [6:0] expL_q[$];
  logic [2:0] selModel = 3'd0;

  int obsMWrites, obsMWriteEdge, obsMErrs, obsMErrEdge, obsMBusy;
  int obsLWrites, obsLWriteEdge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {mux_sel, busy, wb_err, wb_ack, reg_write} observed after edge e of a
  // transaction whose request is sampled at edge 0, derived from the timing rules.
  function automatic logic [6:0] expAt(input int t, input int src, input int k, input int f,
                                       input int e, input logic [2:0] sel);
    bit blockable, wr, w, er, b;
    int lastEdge, busyLen;
    w = 0; er = 0; b = 0; wr = 0; lastEdge = 0; busyLen = 0;
    blockable = (src >= 1 && src <= 3);
    if (f != 0) begin
      if (src == 7) begin
        er = (e == 0);
      end else begin
        if (!blockable || k == 0) begin lastEdge = 0; wr = 1; end
        else if (k <= t) begin lastEdge = k; wr = 1; end
        else begin lastEdge = t; wr = 0; end
        if (f >= 1 && f <= lastEdge) begin
          b = (e < f);
        end else begin
          busyLen = wr ? lastEdge + 1 : lastEdge;
          b  = (e < busyLen);
          w  = wr && (e == lastEdge);
          er = !wr && (e == lastEdge);
        end
      end
    end
    return {sel, b, er, w, w};
  endfunction

  function automatic int busyLenOf(input int t, input int src, input int k, input int f);
    int n = 0;
    logic [6:0] v;
    for (int e = 0; e < k + 3; e++) begin
      v = expAt(t, src, k, f, e, 3'd0);
      if (v[3]) n++;
    end
    return n;
  endfunction

  task automatic tick(input int e);
    logic [6:0] om, ol, em, el;
    @(posedge clk);
    #1;
    om = {muxSelM, busyM, wbErrM, wbAckM, regWriteM};
    ol = {muxSelL, busyL, wbErrL, wbAckL, regWriteL};
    em = expM_q.pop_front();
    el = expL_q.pop_front();
    check("cyc_main", 32'(om), 32'(em));
    check("cyc_long", 32'(ol), 32'(el));
    if (regWriteM) begin obsMWrites++; obsMWriteEdge = e; end
    if (wbErrM) begin obsMErrs++; obsMErrEdge = e; end
    if (busyM) obsMBusy++;
    if (regWriteL) begin obsLWrites++; obsLWriteEdge = e; end
  endtask

  // ---------------- driver ----------------
  // k: edges the relevant block input is held high from the request edge; f: flush edge.
  task automatic runTxn(input int src, input int k, input int f, input bit noise,
                        input int gap);
    int bm, bl, bMin, len;
    logic [2:0] selExp;
    bm = busyLenOf(TM, src, k, f);
    bl = busyLenOf(TL, src, k, f);
    bMin = (bm < bl) ? bm : bl;
    len = ((bm > bl) ? bm : bl) + 1 + gap;
    selExp = (src != 7 && f != 0) ? 3'(src) : selModel;
    for (int e = 0; e < len; e++) begin
      expM_q.push_back(expAt(TM, src, k, f, e, selExp));
      expL_q.push_back(expAt(TL, src, k, f, e, selExp));
    end
    selModel = selExp;
    obsMWrites = 0; obsMWriteEdge = -1; obsMErrs = 0; obsMErrEdge = -1; obsMBusy = 0;
    obsLWrites = 0; obsLWriteEdge = -1;
    for (int e = 0; e < len; e++) begin
      wb_req = (e == 0) || (noise && e >= 1 && e <= bMin && ($urandom_range(0, 1) == 1));
      wb_src = (e == 0) ? 3'(src) : 3'($urandom_range(0, 7));
      if (src == 1) begin
        mem_wait = (e < k);
        md_busy  = 1'($urandom_range(0, 1));
      end else if (src == 2 || src == 3) begin
        md_busy  = (e < k);
        mem_wait = 1'($urandom_range(0, 1));
      end else begin
        mem_wait = (e < k);
        md_busy  = (e < k);
      end
      flush = (e == f);
      tick(e);
    end
  endtask

  typedef struct {
    int src; int k; int f; bit noise; int gap;
    int mWr; int mWrEdge; int mErr; int mErrEdge; int mBusy;
    int lWr; int lWrEdge;
  } vec_t;

  vec_t vecs[14];

  initial begin
    //          src k  f  nz gap mWr mE mErr mErrE mBusy lWr lE
    vecs[0]  = '{0, 0, -1, 0, 0,  1, 0,  0, -1, 1,  1, 0};
    vecs[1]  = '{4, 2, -1, 0, 0,  1, 0,  0, -1, 1,  1, 0};
    vecs[2]  = '{5, 0, -1, 0, 1,  1, 0,  0, -1, 1,  1, 0};
    vecs[3]  = '{6, 1, -1, 1, 0,  1, 0,  0, -1, 1,  1, 0};
    vecs[4]  = '{1, 3, -1, 1, 1,  1, 3,  0, -1, 4,  1, 3};
    vecs[5]  = '{2, 5, -1, 0, 1,  0, -1, 1, 4,  4,  1, 5};
    vecs[6]  = '{3, 9, -1, 0, 0,  0, -1, 1, 4,  4,  1, 9};
    vecs[7]  = '{3, 4, -1, 0, 0,  1, 4,  0, -1, 5,  1, 4};
    vecs[8]  = '{7, 0, -1, 0, 0,  0, -1, 1, 0,  0,  0, -1};
    vecs[9]  = '{1, 3, 2,  0, 0,  0, -1, 0, -1, 2,  0, -1};
    vecs[10] = '{0, 0, 1,  0, 0,  1, 0,  0, -1, 1,  1, 0};
    vecs[11] = '{2, 0, 0,  0, 0,  0, -1, 0, -1, 0,  0, -1};
    vecs[12] = '{1, 9, 4,  0, 0,  0, -1, 0, -1, 4,  0, -1};
    vecs[13] = '{1, 2, 3,  0, 0,  1, 2,  0, -1, 3,  1, 2};

    // reset held with a live request on the wire
    rst_n = 1'b0; wb_req = 1'b1; wb_src = 3'd3; mem_wait = 1'b1; md_busy = 1'b1;
    flush = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_main", {27'd0, muxSelM, busyM, wbErrM, wbAckM, regWriteM}, 32'd0);
      check("rst_long", {27'd0, muxSelL, busyL, wbErrL, wbAckL, regWriteL}, 32'd0);
      check("rst_state", {30'd0, dbgM}, 32'd0);
    end
    rst_n = 1'b1; wb_req = 1'b0;
    #1;
    check("rel_sel", 32'(muxSelM), 32'd0);
    check("rel_busy", 32'(busyM), 32'd0);

    // directed table
    for (int i = 0; i < 14; i++) begin
      runTxn(vecs[i].src, vecs[i].k, vecs[i].f, vecs[i].noise, vecs[i].gap);
      check($sformatf("v%0d_writes", i), 32'(obsMWrites), 32'(vecs[i].mWr));
      check($sformatf("v%0d_wr_edge", i), 32'(obsMWriteEdge), 32'(vecs[i].mWrEdge));
      check($sformatf("v%0d_errs", i), 32'(obsMErrs), 32'(vecs[i].mErr));
      check($sformatf("v%0d_err_edge", i), 32'(obsMErrEdge), 32'(vecs[i].mErrEdge));
      check($sformatf("v%0d_busy", i), 32'(obsMBusy), 32'(vecs[i].mBusy));
      check($sformatf("v%0d_long_writes", i), 32'(obsLWrites), 32'(vecs[i].lWr));
      check($sformatf("v%0d_long_wr_edge", i), 32'(obsLWriteEdge), 32'(vecs[i].lWrEdge));
    end

    // reset while waiting: the pending write is lost
    wb_req = 1'b1; wb_src = 3'd1; mem_wait = 1'b1; md_busy = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, busyM & busyL}, 32'd1);
    wb_req = 1'b0; rst_n = 1'b0;
    #1;
    check("midrst_main", {27'd0, muxSelM, busyM, wbErrM, wbAckM, regWriteM}, 32'd0);
    check("midrst_long", {27'd0, muxSelL, busyL, wbErrL, wbAckL, regWriteL}, 32'd0);
    mem_wait = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("midrst_nowrite", {30'd0, regWriteM, regWriteL}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_idle", {27'd0, muxSelM, busyM, wbErrM, wbAckM, regWriteM}, 32'd0);
    selModel = 3'd0;

    // random transactions
    for (int n = 0; n < 300; n++) begin
      int src, k, f;
      src = $urandom_range(0, 7);
      k = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 40) : $urandom_range(0, 7);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, k + 1) : -1;
      runTxn(src, k, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
